// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and register reset values.
package dmem_mmio_pkg;

  localparam logic [2:0] OFF_TCOUNT = 3'd0;
  localparam logic [2:0] OFF_TCMP   = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_TXDATA = 3'd3;
  localparam logic [2:0] OFF_LED    = 3'd4;

  localparam int ST_MATCH = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO feeding the serial transmitter. A push into a full FIFO is accepted
// only if a pop frees a slot on the same edge; otherwise it is dropped and flagged.
module tx_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign ovf_o   = push_i & full_o & ~do_pop;

  always_comb begin
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an 8-word MMIO window (timer/compare,
// STATUS, TX FIFO, LED). All reads return pre-edge state one edge later.
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] led,
  output logic        irq_timer
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram_q [RAM_DEPTH];
  logic        ram_hit, mmio_hit;
  logic [2:0]  off;
  logic        wr_tcount, wr_tcmp, wr_status, wr_txdata, wr_led;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;
  logic [15:0] led_q, led_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [31:0]   status_w;

  assign ram_hit  = (address_dmem[31:RAM_AW] == '0);
  assign mmio_hit = ~ram_hit & (address_dmem[31:3] == MMIO_BASE[31:3]);
  assign off      = address_dmem[2:0];

  assign wr_tcount = wren & mmio_hit & (off == OFF_TCOUNT);
  assign wr_tcmp   = wren & mmio_hit & (off == OFF_TCMP);
  assign wr_status = wren & mmio_hit & (off == OFF_STATUS);
  assign wr_txdata = wren & mmio_hit & (off == OFF_TXDATA);
  assign wr_led    = wren & mmio_hit & (off == OFF_LED);

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (wr_txdata),
    .data_i  (data[7:0]),
    .pop_i   (tx_valid & tx_ready),
    .data_o  (tx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ovf_o   (fifo_ovf)
  );

  assign tx_valid  = ~fifo_empty;
  assign led       = led_q;
  assign irq_timer = match_q;
  assign q_dmem    = rdata_q;
  assign status_w  = {28'b0, ovf_q, fifo_empty, fifo_full, match_q};

  always_comb begin
    rdata_d = '0;
    if (ram_hit) begin
      rdata_d = ram_q[address_dmem[RAM_AW-1:0]];
    end else if (mmio_hit) begin
      case (off)
        OFF_TCOUNT: rdata_d = tcount_q;
        OFF_TCMP:   rdata_d = tcmp_q;
        OFF_STATUS: rdata_d = status_w;
        OFF_TXDATA: rdata_d = {{(32-CW){1'b0}}, fifo_count};
        OFF_LED:    rdata_d = {16'b0, led_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Sticky bits: a set on the same edge as a write-1-to-clear wins.
  always_comb begin
    tcount_d = wr_tcount ? data : tcount_q + 32'd1;
    tcmp_d   = wr_tcmp ? data : tcmp_q;
    match_d  = (tcount_q == tcmp_q) | (match_q & ~(wr_status & data[ST_MATCH]));
    ovf_d    = fifo_ovf | (ovf_q & ~(wr_status & data[ST_OVF]));
    led_d    = wr_led ? data[15:0] : led_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      tcount_q <= '0;
      tcmp_q   <= TCMP_RESET;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      led_q    <= '0;
    end else begin
      rdata_q  <= rdata_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      led_q    <= led_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wren && ram_hit) ram_q[address_dmem[RAM_AW-1:0]] <= data;
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, timer/compare, STATUS, TX FIFO,
// LED and asynchronous reset, with hand-computed expected values.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] led;
  logic        irq_timer;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] A_TCOUNT = 32'h0000_FF00;
  localparam logic [31:0] A_TCMP   = 32'h0000_FF01;
  localparam logic [31:0] A_STATUS = 32'h0000_FF02;
  localparam logic [31:0] A_TXDATA = 32'h0000_FF03;
  localparam logic [31:0] A_LED    = 32'h0000_FF04;
  localparam logic [31:0] A_RSVD   = 32'h0000_FF05;

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .led          (led),
    .irq_timer    (irq_timer)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    address_dmem = a;
    wren = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_q", q_dmem, 32'h0);
    check("rst_txv", {31'b0, tx_valid}, 32'h0);
    check("rst_txd", {24'b0, tx_data}, 32'h0);
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_irq", {31'b0, irq_timer}, 32'h0);
    reset = 1'b0;

    // RAM write/read and unmapped read
    wr(32'd5, 32'hDEAD_BEEF);
    rd(32'd5);
    check("ram_rd5", q_dmem, 32'hDEAD_BEEF);
    wr(32'd4096, 32'h1234_5678);
    rd(32'd4096);
    check("unmapped_rd", q_dmem, 32'h0);

    // Same-edge read/write hazard returns old word
    wr(32'd7, 32'd1);
    wr(32'd7, 32'd2);
    check("ram_old", q_dmem, 32'd1);
    rd(32'd7);
    check("ram_new", q_dmem, 32'd2);

    // LED and reserved offset
    wr(A_LED, 32'h1234_A5A5);
    check("led_out", {16'b0, led}, 32'h0000_A5A5);
    rd(A_LED);
    check("led_rd", q_dmem, 32'h0000_A5A5);
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD);
    check("rsvd_rd", q_dmem, 32'h0);

    // Timer compare: count written to 0, match seen when count==10
    wr(A_TCMP, 32'd10);
    wr(A_TCOUNT, 32'd0);
    rd(A_TCOUNT);
    check("tcount_0", q_dmem, 32'd0);
    for (int i = 0; i < 9; i++) rd(A_TCOUNT);
    check("tcount_9", q_dmem, 32'd9);
    check("irq_pre", {31'b0, irq_timer}, 32'h0);
    rd(A_TCOUNT);
    check("tcount_10", q_dmem, 32'd10);
    check("irq_set", {31'b0, irq_timer}, 32'h1);
    wr(A_STATUS, 32'h1);
    check("status_rd", q_dmem, 32'h5);
    check("irq_w1c", {31'b0, irq_timer}, 32'h0);

    // Timer wrap
    wr(A_TCOUNT, 32'hFFFF_FFFF);
    rd(A_TCOUNT);
    check("tcount_max", q_dmem, 32'hFFFF_FFFF);
    rd(A_TCOUNT);
    check("tcount_wrap", q_dmem, 32'h0);

    // Match set and W1C on the same edge: set wins
    wr(A_TCOUNT, 32'd100);
    wr(A_TCMP, 32'd101);
    wr(A_STATUS, 32'h1);
    check("irq_setwins", {31'b0, irq_timer}, 32'h1);
    wr(A_STATUS, 32'h1);
    check("irq_clr2", {31'b0, irq_timer}, 32'h0);

    // FIFO overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'h41 + i);
    rd(A_TXDATA);
    check("fifo_cnt4", q_dmem, 32'd4);
    rd(A_STATUS);
    check("status_ovf", q_dmem, 32'hA);
    check("txd_head", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain", {24'b0, tx_data}, 32'h41 + i);
    end
    tick();
    check("drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    wr(A_STATUS, 32'h8);
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h51 + i);
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h55);
    tx_ready = 1'b0;
    rd(A_TXDATA);
    check("pp_cnt", q_dmem, 32'd4);
    rd(A_STATUS);
    check("pp_status", q_dmem, 32'h2);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_drain", {24'b0, tx_data}, 32'h52 + i);
      tick();
    end
    check("pp_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Async reset mid-operation
    wr(A_TCMP, 32'd5);
    wr(A_TCOUNT, 32'd5);
    rd(A_TCOUNT);
    check("irq_before_rst", {31'b0, irq_timer}, 32'h1);
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h61 + i);
    wr(A_LED, 32'h0000_A5A5);
    rd(A_LED);
    check("q_before_rst", q_dmem, 32'h0000_A5A5);
    check("txv_before_rst", {31'b0, tx_valid}, 32'h1);
    #3 reset = 1'b1;
    #1;
    check("arst_txv", {31'b0, tx_valid}, 32'h0);
    check("arst_txd", {24'b0, tx_data}, 32'h0);
    check("arst_led", {16'b0, led}, 32'h0);
    check("arst_q", q_dmem, 32'h0);
    check("arst_irq", {31'b0, irq_timer}, 32'h0);
    #1 reset = 1'b0;
    rd(A_TCOUNT);
    check("post_tc0", q_dmem, 32'd0);
    rd(A_TCOUNT);
    check("post_tc1", q_dmem, 32'd1);
    rd(A_TCMP);
    check("post_tcmp", q_dmem, 32'hFFFF_FFFF);
    rd(A_STATUS);
    check("post_status", q_dmem, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder side of the processor's data-memory interface (address_dmem, data, wren, q_dmem), instantiated in the wrapper in place of a bare dmem. Serves word-addressed RAM plus a small memory-mapped register window containing a free-running timer with compare, an LED register and a 4-deep byte TX FIFO. The FIFO drains through a valid/ready handshake to a downstream serial transmitter.

Parameters:
RAM_AW, 12, RAM word-address width (RAM_DEPTH = 2^RAM_AW words of 32 bits)
MMIO_BASE, 32'h0000_FF00, word address of MMIO offset 0; the window is MMIO_BASE..MMIO_BASE+7
FIFO_DEPTH, 4, TX FIFO entries (power of two)

Ports:
clock  in  1  master clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
address_dmem  in  32  word address from processor
data  in  32  write data from processor
wren  in  1  write enable from processor
q_dmem  out  32  registered read data to processor
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  downstream accepts tx_data this cycle
led  out  16  LED register contents
irq_timer  out  1  sticky timer-match flag

Behaviour:
- Decode: RAM hit when address_dmem < 2^RAM_AW. MMIO hit when address_dmem[31:3] == MMIO_BASE[31:3]. Anything else is unmapped: reads return 0, writes are ignored.
- Read latency: exactly 1 rising edge. q_dmem <= read value of address_dmem sampled at that edge.
- Same-edge read and write to one RAM address returns the OLD word.
- RAM write on rising edge when wren & RAM hit. RAM is not cleared by reset.
- MMIO offsets (address_dmem[2:0]):
  - 0 TIMER_COUNT: RW. Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0. A write loads data; the write wins over the increment that cycle.
  - 1 TIMER_CMP: RW, 32 bits.
  - 2 STATUS: RO except write-1-to-clear on bits 0 and 3. Bit 0 match (sticky), bit 1 fifo_full, bit 2 fifo_empty, bit 3 overflow (sticky). Bits 31:4 read 0.
  - 3 TX_DATA: write pushes data[7:0]; read returns FIFO count zero-extended.
  - 4 LED: RW, bits 15:0; upper bits read 0.
  - 5..7: reserved, read 0, writes ignored.
- Timer match: when TIMER_COUNT == TIMER_CMP (pre-increment value), set STATUS[0]. A set and a W1C in the same cycle leave the bit SET. irq_timer = STATUS[0].
- FIFO:
  - pop when tx_valid & tx_ready; tx_data = head entry, tx_valid = (count != 0).
  - A push while full, with no pop in the same cycle, is dropped and sets STATUS[3].
  - Push and pop in the same cycle: both take effect (including when full or empty-with-push-only). Count is unchanged when both occur.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Reads of MMIO reflect state before that edge's updates (same old-data rule as RAM).
- Reset (async, any time, including mid-transfer): q_dmem=0, TIMER_COUNT=0, TIMER_CMP=32'hFFFF_FFFF, STATUS sticky bits=0, led=0, FIFO empty (tx_valid=0, tx_data=0), irq_timer=0. The first increment happens on the first rising edge after reset deasserts.

Decomposition:
- Shared package dmem_mmio_pkg:
  - MMIO offset constants: OFF_TCOUNT, OFF_TCMP, OFF_STATUS, OFF_TXDATA, OFF_LED
  - STATUS bit indices: ST_MATCH, ST_FULL, ST_EMPTY, ST_OVF
  - TIMER_CMP reset value
- One sub-module, tx_byte_fifo: parameterised depth, push/pop, count, full/empty, simultaneous push/pop rule. The top level holds decode, RAM, timer and registers.

Test Plan:
- RAM write/read: write 32'hDEADBEEF to addr 5, then read addr 5 -> q_dmem = 32'hDEADBEEF one edge after the read address is sampled. Read addr 4096 -> 0.
- Same-edge RAM hazard: addr 7 holds 1; write 2 to addr 7 -> q_dmem = 1 that edge, a following read -> 2.
- Timer: write TIMER_CMP=10 and TIMER_COUNT=0 -> irq_timer rises after the edge where count==10. W1C STATUS=1 on a non-match cycle -> irq_timer=0. Write COUNT=32'hFFFF_FFFF -> next value 0.
- FIFO overflow: tx_ready=0, push 5 bytes 0x41..0x45 -> count 4, STATUS[1]=1, STATUS[3]=1, tx_data=0x41. Raise tx_ready -> bytes emerge 0x41..0x44 on consecutive cycles, then tx_valid=0.
- Full push+pop: FIFO full, tx_ready=1, push 0x55 the same cycle -> count stays 4, no overflow, 0x55 emitted last.
- Async reset mid-operation: assert reset between edges with FIFO holding 3 bytes and led=16'hA5A5 -> immediately tx_valid=0, led=0, q_dmem=0, irq_timer=0.
